// File: rtl/bios_loader_rom.sv
// Field-loadable BIOS instruction store: byte-serial loader with XOR checksum
// and a registered one-cycle fetch port that reads as NOP without a valid image.
module bios_loader_rom #(
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned BPW        = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_data,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid
);

    localparam int unsigned BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned AW  = BPW * 8;

    typedef enum logic [1:0] {
        S_READY,
        S_LOAD,
        S_CHECK,
        S_ERROR
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   word_idx_q, word_idx_d;
    logic [BIW-1:0]          byte_idx_q, byte_idx_d;
    logic [AW-1:0]           asm_q, asm_d;
    logic [7:0]              csum_q, csum_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   fdata_q, fdata_d;
    logic                    fvalid_q, fvalid_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    xfer;

    assign load_ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign load_busy   = load_ready;
    assign load_error  = (state_q == S_ERROR);
    assign load_done   = done_q;
    assign fetch_data  = fdata_q;
    assign fetch_valid = fvalid_q;
    assign xfer        = load_valid && load_ready;

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        csum_d     = csum_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_data    = '0;
        fdata_d    = '0;
        fvalid_d   = 1'b0;

        // Fetch depends only on the current state, so it is independent of load_start.
        if (state_q == S_READY && fetch_en) begin
            fdata_d  = mem_q[fetch_addr];
            fvalid_d = 1'b1;
        end

        if (load_start) begin
            state_d    = S_LOAD;
            word_idx_d = '0;
            byte_idx_d = '0;
            asm_d      = '0;
            csum_d     = '0;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        csum_d = csum_q ^ load_data;
                        for (int unsigned b = 0; b < BPW; b++) begin
                            if (byte_idx_q == BIW'(b)) asm_d[8*b +: 8] = load_data;
                        end
                        if (byte_idx_q == BIW'(BPW - 1)) begin
                            wr_en      = 1'b1;
                            wr_data    = asm_d[DATA_WIDTH-1:0];
                            asm_d      = '0;
                            byte_idx_d = '0;
                            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                            if (word_idx_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_CHECK;
                        end else begin
                            byte_idx_d = byte_idx_q + BIW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        if (load_data == csum_q) begin
                            state_d = S_READY;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_READY;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            done_q     <= 1'b0;
            fdata_q    <= '0;
            fvalid_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            csum_q     <= csum_d;
            done_q     <= done_d;
            fdata_q    <= fdata_d;
            fvalid_q   <= fvalid_d;
            if (wr_en) mem_q[word_idx_q] <= wr_data;
        end
    end

endmodule

// File: doc/bios_loader_rom.md
# bios_loader_rom

Parametrised, field-loadable successor to the hardcoded BIOS instruction store of the i281 multicycle CPU. It holds `DEPTH` instruction words of `DATA_WIDTH` bits; bit `DATA_WIDTH-1` is the multicycle flag. The words are loaded at run time over a byte-serial valid/ready channel protected by an XOR checksum. The CPU fetch unit reads the store through a registered one-cycle port, and the store reads as all-zero (NOP) whenever it holds no valid image.

## Interface
- `DATA_WIDTH`, 17, instruction width; MSB is the multicycle flag.
- `DEPTH`, 16, number of words; a power of two, at least 2.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, fetch address width.
- `BPW`, `(DATA_WIDTH+7)/8`, bytes per word (3 at the defaults).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse that begins a load session.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  8  load byte.
- `load_ready`  out  1  the block accepts a byte this cycle.
- `load_busy`  out  1  high in LOAD or CHECK.
- `load_done`  out  1  one-cycle pulse when an image is accepted.
- `load_error`  out  1  high while in ERROR (checksum mismatch).
- `fetch_en`  in  1  fetch request.
- `fetch_addr`  in  `ADDR_WIDTH`  word address.
- `fetch_data`  out  `DATA_WIDTH`  registered fetch result.
- `fetch_valid`  out  1  `fetch_data` is a valid image word.

## Operation
- States are READY, LOAD, CHECK and ERROR.
- Reset:
  - The state goes to READY.
  - Every memory word is cleared to 0, so the store holds the all-NOP BIOS.
  - `fetch_data`=0, and `fetch_valid`, `load_ready`, `load_busy`, `load_done` and `load_error` are all 0.
  - The word index, byte index, assembly register and checksum accumulator are all 0.
- Handshake: a byte transfers on a cycle where `load_valid && load_ready`. `load_ready` is high exactly in LOAD and CHECK.
- `load_start` in any state, including mid-LOAD or mid-CHECK:
  - The next state is LOAD.
  - The indices, assembly register and accumulator are zeroed.
  - `load_error` clears.
  - A byte offered in the same cycle is ignored.
- LOAD:
  - Each accepted byte is XORed into the accumulator.
  - The byte is placed in the assembly register at bit offset 8×(byte index), little-endian.
  - On byte index `BPW-1`, `mem[word_idx]` is written with the low `DATA_WIDTH` bits. Excess high bits of the last byte are discarded but are still included in the checksum.
  - After the last word of `DEPTH` is written, the state moves to CHECK.
- CHECK: the next accepted byte is compared with the accumulator.
  - If equal, the state moves to READY and `load_done` pulses for one cycle.
  - If not equal, the state moves to ERROR.
- ERROR: the memory keeps the partially trusted data but is not fetchable. Only `load_start` or reset leaves ERROR.
- Fetch behaviour:
  - In READY with `fetch_en`=1: `fetch_data` ← `mem[fetch_addr]` and `fetch_valid` ← 1 on the next edge.
  - In any other state, or with `fetch_en`=0: `fetch_data` ← 0 and `fetch_valid` ← 0.
- Memory writes happen only in LOAD and fetches only in READY, so a same-cycle read/write conflict cannot occur.

## Timing
- Fetch latency is exactly 1 cycle, giving one word per cycle when `fetch_en` is held.
- A full load takes `DEPTH×BPW`+1 accepted bytes: 49 at the defaults. It needs at least 50 cycles counting the `load_start` cycle.
- `load_done` is asserted in the cycle after the checksum byte is accepted, and the state is READY in that same cycle. A fetch issued in that cycle returns new data one cycle later.
- The state follows LOAD→CHECK on the edge that writes the last word. The next byte offered is treated as the checksum.
- `load_busy` rises the cycle after `load_start` and falls the cycle after the checksum byte is accepted.
- A `load_valid` gap stalls the transfer with no effect. The block never times out.
- Asserting `rst_n` low mid-load or mid-fetch forces the reset values immediately, asynchronously, and the memory returns to all zero.

## Test plan
- Reset then fetch: release `rst_n`, set `fetch_en`=1 and sweep `fetch_addr` 0..15. Expect `fetch_data`=0 and `fetch_valid`=1 one cycle after each request.
- Good load:
  - Load word i = `17'h10000|i` for i=0..15, as bytes i, 0x00, 0x01.
  - The checksum is the XOR of all 48 bytes, which is 0x00.
  - Expect `load_done` for one cycle, `load_error`=0, and a fetch of address 5 returning `17'h10005`.
- Bad checksum: perform the same load with checksum byte 0xFF. Expect `load_error`=1, `fetch_valid`=0 and `fetch_data`=0 for all addresses.
- Restart mid-load: after 20 bytes, pulse `load_start`, then send the full good image. Expect `load_done`, and address 0 returning `17'h10000` with no residue from the aborted session.
- Backpressure and gaps: toggle `load_valid` randomly during the good load. Expect the image and checksum to be identical to the gap-free case, and `load_ready` to be 0 once READY is reached.
- Asynchronous reset mid-CHECK: drop `rst_n` before the checksum byte. Expect all outputs at their reset values immediately, and address 3 returning 0 after release.
